// File: rtl/philv_mem_pkg.sv
// Shared types for the memory arbiter: bus width default, port IDs, and the
// owner record that carries a grant into its response cycle.
package philv_mem_pkg;

   localparam int N_DEFAULT = 32;
   localparam int CNT_W     = 16;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_LS = 1'b1
   } port_id_t;

   typedef struct packed {
      logic     valid;
      port_id_t port;
      logic     we;
      logic     err;
   } owner_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant selection between fetch and load/store requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise ls wins.
module mem_arb_pick
   import philv_mem_pkg::*;
(
   input  logic     if_req,
   input  logic     ls_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  port_id_t last_port,
`endif
   output logic     if_gnt,
   output logic     ls_gnt
);

   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (if_req && ls_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         // the port that did not win last time gets this one
         if (last_port == PORT_LS) begin
            if_gnt = 1'b1;
         end else begin
            ls_gnt = 1'b1;
         end
`else
         ls_gnt = 1'b1;
`endif
      end else begin
         if_gnt = if_req;
         ls_gnt = ls_req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter for instruction fetch and load/store with one-cycle
// response latency. Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention handling.
module mem_arbiter
   import philv_mem_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,

   input  logic         if_req,
   input  logic [N-1:0] if_addr,
   output logic         if_gnt,
   output logic         if_rvalid,
   output logic [N-1:0] if_rdata,

   input  logic         ls_req,
   input  logic         ls_we,
   input  logic [N-1:0] ls_addr,
   input  logic [N-1:0] ls_wdata,
   output logic         ls_gnt,
   output logic         ls_rvalid,
   output logic [N-1:0] ls_rdata,
   output logic         ls_err,

   output logic         mem_rdEna,
   output logic         mem_wrEna,
   output logic [N-1:0] mem_rdAddr,
   output logic [N-1:0] mem_wrAddr,
   output logic [N-1:0] mem_wrData,
   input  logic [N-1:0] mem_rdData
);

   localparam logic [N-1:0] WORD_MASK = ~N'(3);

   logic             pick_if;
   logic             pick_ls;
   logic             ls_mis;
   owner_t           owner;
   logic [CNT_W-1:0] cnt_if;
   logic [CNT_W-1:0] cnt_ls;

   assign ls_mis = (ls_addr[1:0] != 2'b00);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   port_id_t last_port;

   // reset value makes ls the winner of the first contested cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_port <= PORT_IF;
      end else if (if_gnt) begin
         last_port <= PORT_IF;
      end else if (ls_gnt) begin
         last_port <= PORT_LS;
      end
   end

   mem_arb_pick u_pick (
      .if_req    (if_req),
      .ls_req    (ls_req),
      .last_port (last_port),
      .if_gnt    (pick_if),
      .ls_gnt    (pick_ls)
   );
`else
   mem_arb_pick u_pick (
      .if_req (if_req),
      .ls_req (ls_req),
      .if_gnt (pick_if),
      .ls_gnt (pick_ls)
   );
`endif

   // grants are combinational but must read 0 the instant reset asserts
   assign if_gnt = pick_if & ~rst;
   assign ls_gnt = pick_ls & ~rst;

   always_comb begin
      mem_rdEna  = 1'b0;
      mem_wrEna  = 1'b0;
      mem_rdAddr = '0;
      mem_wrAddr = '0;
      mem_wrData = '0;
      if (if_gnt) begin
         mem_rdEna  = 1'b1;
         mem_rdAddr = if_addr & WORD_MASK;
      end else if (ls_gnt && !ls_mis) begin
         if (ls_we) begin
            mem_wrEna  = 1'b1;
            mem_wrAddr = ls_addr;
            mem_wrData = ls_wdata;
         end else begin
            mem_rdEna  = 1'b1;
            mem_rdAddr = ls_addr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner <= '0;
      end else begin
         owner.valid <= if_gnt | ls_gnt;
         owner.port  <= ls_gnt ? PORT_LS : PORT_IF;
         owner.we    <= ls_gnt & ls_we;
         owner.err   <= ls_gnt & ls_mis;
      end
   end

   assign if_rvalid = owner.valid && (owner.port == PORT_IF);
   assign ls_rvalid = owner.valid && (owner.port == PORT_LS);
   assign ls_err    = ls_rvalid && owner.err;
   assign if_rdata  = if_rvalid ? mem_rdData : '0;
   assign ls_rdata  = (ls_rvalid && !owner.we && !owner.err) ? mem_rdData : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_if <= '0;
         cnt_ls <= '0;
      end else begin
         if (if_gnt) cnt_if <= sat_inc(cnt_if);
         if (ls_gnt) cnt_ls <= sat_inc(cnt_ls);
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle registered memory model.
module tb_mem_arbiter;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         if_req = 1'b0;
   logic [N-1:0] if_addr = '0;
   logic         if_gnt, if_rvalid;
   logic [N-1:0] if_rdata;
   logic         ls_req = 1'b0;
   logic         ls_we = 1'b0;
   logic [N-1:0] ls_addr = '0;
   logic [N-1:0] ls_wdata = '0;
   logic         ls_gnt, ls_rvalid, ls_err;
   logic [N-1:0] ls_rdata;
   logic         mem_rdEna, mem_wrEna;
   logic [N-1:0] mem_rdAddr, mem_wrAddr, mem_wrData;
   logic [N-1:0] mem_rdData = '0;

   logic [N-1:0] tb_mem [0:63];
   int vectors = 0;
   int miscompares = 0;

   mem_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_rdEna(mem_rdEna), .mem_wrEna(mem_wrEna),
      .mem_rdAddr(mem_rdAddr), .mem_wrAddr(mem_wrAddr), .mem_wrData(mem_wrData),
      .mem_rdData(mem_rdData)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rdEna) mem_rdData <= tb_mem[mem_rdAddr[7:2]];
      if (mem_wrEna) tb_mem[mem_wrAddr[7:2]] <= mem_wrData;
   end

   task automatic test_reset();
      // requests present while in reset must not produce grants
      if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_addr = 32'h20;
      #1;
      vectors++;
      if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, ls_err, mem_rdEna, mem_wrEna} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl got %b want 0000000",
                  {if_gnt, ls_gnt, if_rvalid, ls_rvalid, ls_err, mem_rdEna, mem_wrEna});
      end
      vectors++;
      if ({mem_rdAddr, mem_wrAddr, mem_wrData, if_rdata, ls_rdata} !== '0) begin
         miscompares++;
         $display("FAIL reset_data got %h %h %h %h %h want all 0",
                  mem_rdAddr, mem_wrAddr, mem_wrData, if_rdata, ls_rdata);
      end
      if_req = 1'b0; ls_req = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      vectors++;
      if ({if_gnt, mem_rdEna, mem_wrEna} !== 3'b110) begin
         miscompares++;
         $display("FAIL fetch_gnt got %b want 110", {if_gnt, mem_rdEna, mem_wrEna});
      end
      vectors++;
      if (mem_rdAddr !== 32'h10) begin
         miscompares++;
         $display("FAIL fetch_addr got %h want 00000010", mem_rdAddr);
      end
      @(negedge clk);
      if_req = 1'b0; if_addr = '0;
      #1;
      vectors++;
      if ({if_rvalid, ls_rvalid} !== 2'b10) begin
         miscompares++;
         $display("FAIL fetch_rvalid got %b want 10", {if_rvalid, ls_rvalid});
      end
      vectors++;
      if (if_rdata !== 32'hDEADBEEF || ls_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL fetch_rdata got %h/%h want deadbeef/00000000", if_rdata, ls_rdata);
      end
      vectors++;
      if ({mem_rdEna, mem_wrEna} !== 2'b00 || mem_rdAddr !== 32'h0) begin
         miscompares++;
         $display("FAIL idle_mem got %b %h want 00 00000000", {mem_rdEna, mem_wrEna}, mem_rdAddr);
      end
   endtask

   task automatic test_store_load();
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h12345678;
      #1;
      vectors++;
      if ({ls_gnt, mem_wrEna, mem_rdEna} !== 3'b110) begin
         miscompares++;
         $display("FAIL store_gnt got %b want 110", {ls_gnt, mem_wrEna, mem_rdEna});
      end
      vectors++;
      if (mem_wrAddr !== 32'h20 || mem_wrData !== 32'h12345678) begin
         miscompares++;
         $display("FAIL store_bus got %h/%h want 00000020/12345678", mem_wrAddr, mem_wrData);
      end
      @(negedge clk);
      ls_we = 1'b0; ls_wdata = '0;
      #1;
      vectors++;
      if ({ls_rvalid, ls_err} !== 2'b10 || ls_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL store_ack got %b %h want 10 00000000", {ls_rvalid, ls_err}, ls_rdata);
      end
      vectors++;
      if ({ls_gnt, mem_rdEna, mem_wrEna} !== 3'b110 || mem_rdAddr !== 32'h20) begin
         miscompares++;
         $display("FAIL load_gnt got %b %h want 110 00000020", {ls_gnt, mem_rdEna, mem_wrEna}, mem_rdAddr);
      end
      @(negedge clk);
      ls_req = 1'b0; ls_addr = '0;
      #1;
      vectors++;
      if ({ls_rvalid, ls_err, if_rvalid} !== 3'b100 || ls_rdata !== 32'h12345678) begin
         miscompares++;
         $display("FAIL load_data got %b %h want 100 12345678", {ls_rvalid, ls_err, if_rvalid}, ls_rdata);
      end
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h22;
      #1;
      vectors++;
      if ({ls_gnt, mem_rdEna, mem_wrEna} !== 3'b100) begin
         miscompares++;
         $display("FAIL mis_load_gnt got %b want 100", {ls_gnt, mem_rdEna, mem_wrEna});
      end
      @(negedge clk);
      ls_we = 1'b1; ls_addr = 32'h21; ls_wdata = 32'hFFFFFFFF;
      #1;
      vectors++;
      if ({ls_rvalid, ls_err} !== 2'b11 || ls_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL mis_load_err got %b %h want 11 00000000", {ls_rvalid, ls_err}, ls_rdata);
      end
      vectors++;
      if ({ls_gnt, mem_rdEna, mem_wrEna} !== 3'b100) begin
         miscompares++;
         $display("FAIL mis_store_gnt got %b want 100", {ls_gnt, mem_rdEna, mem_wrEna});
      end
      @(negedge clk);
      ls_we = 1'b0; ls_addr = 32'h20; ls_wdata = '0;
      #1;
      vectors++;
      if ({ls_rvalid, ls_err} !== 2'b11 || ls_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL mis_store_err got %b %h want 11 00000000", {ls_rvalid, ls_err}, ls_rdata);
      end
      @(negedge clk);
      ls_req = 1'b0; ls_addr = '0;
      #1;
      vectors++;
      if (ls_rdata !== 32'h12345678 || ls_err !== 1'b0) begin
         miscompares++;
         $display("FAIL mis_no_effect got %h err %b want 12345678 err 0", ls_rdata, ls_err);
      end
   endtask

   task automatic test_contention();
      logic [3:0] exp_ls;
      logic [15:0] exp_cnt_ls, exp_cnt_if;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_ls = 4'b0101;  // bit k = cycle k grant to ls
      exp_cnt_ls = 16'd2; exp_cnt_if = 16'd2;
`else
      exp_ls = 4'b1111;
      exp_cnt_ls = 16'd4; exp_cnt_if = 16'd0;
`endif
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
      for (int k = 0; k < 4; k++) begin
         #1;
         vectors++;
         if ({ls_gnt, if_gnt} !== {exp_ls[k], ~exp_ls[k]}) begin
            miscompares++;
            $display("FAIL contend_gnt%0d got ls=%b if=%b want ls=%b if=%b",
                     k, ls_gnt, if_gnt, exp_ls[k], ~exp_ls[k]);
         end
         if (k > 0) begin
            vectors++;
            if ({ls_rvalid, if_rvalid} !== {exp_ls[k-1], ~exp_ls[k-1]}) begin
               miscompares++;
               $display("FAIL contend_rsp%0d got ls=%b if=%b want ls=%b if=%b",
                        k, ls_rvalid, if_rvalid, exp_ls[k-1], ~exp_ls[k-1]);
            end
         end
         @(negedge clk);
      end
      if_req = 1'b0; ls_req = 1'b0; ls_addr = '0;
      #1;
      vectors++;
      if (dut.cnt_ls !== exp_cnt_ls || dut.cnt_if !== exp_cnt_if) begin
         miscompares++;
         $display("FAIL grant_cnt got ls=%0d if=%0d want ls=%0d if=%0d",
                  dut.cnt_ls, dut.cnt_if, exp_cnt_ls, exp_cnt_if);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h10;
      @(posedge clk);
      #1;
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      #1;
      vectors++;
      if ({if_rvalid, ls_rvalid, ls_err, if_gnt, ls_gnt, mem_rdEna, mem_wrEna} !== 7'b0 ||
          if_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_mid_out got %b %h want 0000000 00000000",
                  {if_rvalid, ls_rvalid, ls_err, if_gnt, ls_gnt, mem_rdEna, mem_wrEna}, if_rdata);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (if_rvalid !== 1'b0) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL rst_mid_stale got %0d if_rvalid cycles want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] exp_data [0:2];
      exp_data[0] = 32'h11111111; exp_data[1] = 32'h22222222; exp_data[2] = 32'h33333333;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            if_req = 1'b1; if_addr = 32'(4 * k);
         end else begin
            if_req = 1'b0; if_addr = '0;
         end
         #1;
         if (k < 3) begin
            vectors++;
            if (if_gnt !== 1'b1 || mem_rdAddr !== 32'(4 * k)) begin
               miscompares++;
               $display("FAIL b2b_gnt%0d got %b %h want 1 %h", k, if_gnt, mem_rdAddr, 32'(4 * k));
            end
         end
         if (k > 0) begin
            vectors++;
            if (if_rvalid !== 1'b1 || if_rdata !== exp_data[k-1]) begin
               miscompares++;
               $display("FAIL b2b_rsp%0d got %b %h want 1 %h", k, if_rvalid, if_rdata, exp_data[k-1]);
            end
         end
         @(negedge clk);
      end
      vectors++;
      if (if_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_end got %b want 0", if_rvalid);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) tb_mem[i] = '0;
      tb_mem[0] = 32'h11111111;
      tb_mem[1] = 32'h22222222;
      tb_mem[2] = 32'h33333333;
      tb_mem[4] = 32'hDEADBEEF;
      test_reset();
      test_fetch();
      test_store_load();
      test_misaligned();
      test_contention();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 32: bus width of every address and data port.
REQ-002 clk  in  1: single clock; all state updates on its rising edge.
REQ-003 rst  in  1: reset, asynchronous and active-high.
REQ-004 if_req  in  1: instruction-fetch read request.
REQ-005 if_addr  in  N: instruction-fetch byte address.
REQ-006 if_gnt  out  1: fetch request accepted this cycle (combinational).
REQ-007 if_rvalid  out  1: fetch read data valid this cycle.
REQ-008 if_rdata  out  N: fetch read data.
REQ-009 ls_req  in  1: load/store request.
REQ-010 ls_we  in  1: 1 = store, 0 = load.
REQ-011 ls_addr  in  N: load/store byte address.
REQ-012 ls_wdata  in  N: store data.
REQ-013 ls_gnt  out  1: load/store request accepted this cycle (combinational).
REQ-014 ls_rvalid  out  1: load/store response this cycle (load data or store ack).
REQ-015 ls_rdata  out  N: load data; 0 for store ack or error.
REQ-016 ls_err  out  1: qualifies ls_rvalid; misaligned access, no memory effect.
REQ-017 mem_rdEna, mem_wrEna  out  1 each: memory read/write enables.
REQ-018 mem_rdAddr, mem_wrAddr, mem_wrData  out  N each: memory address/data.
REQ-019 mem_rdData  in  N: memory read data, registered one cycle after mem_rdEna.

Function
REQ-020 At most one request granted per cycle; a grant drives the memory ports in the same cycle.
REQ-021 Exactly one response (rvalid) is issued per grant, on the cycle after the grant: one-cycle latency, full throughput.
REQ-022 Responses are in grant order; owner register records the granted port and access type for the response cycle.
REQ-023 Read response data is mem_rdData routed to the owner port; the other port's rdata is 0.
REQ-024 Store: mem_wrEna=1, mem_wrAddr=ls_addr, mem_wrData=ls_wdata, mem_rdEna=0; ack has ls_rdata=0.
REQ-025 Load or fetch: mem_rdEna=1, mem_rdAddr=requester address, mem_wrEna=0.
REQ-026 Idle cycle (no grant): mem_rdEna=0, mem_wrEna=0; address/data outputs hold 0.
REQ-027 ls_addr[1:0]!=0 with ls_req: ls_gnt=1, no memory enable, next-cycle ls_rvalid=1, ls_err=1, ls_rdata=0; it consumes the arbitration slot.
REQ-028 if_addr[1:0] is ignored (word fetch); no fetch error path.
REQ-029 Requester must hold req and payload stable until gnt; arbiter never revokes a gnt.
REQ-030 Default arbitration (fixed priority): ls beats if on simultaneous requests.
REQ-031 Counters: 16-bit saturating grant counters, one per port, readable hierarchically only, cleared by reset.

Reset
REQ-032 rst asserted: if_gnt, ls_gnt, both rvalid, ls_err, all mem_* outputs and both rdata outputs = 0 immediately.
REQ-033 Reset mid-operation: the pending response is discarded and no rvalid follows reset release.
REQ-034 First grant possible in the first clk edge cycle after rst deassertion; round-robin pointer resets to favour ls.

Configuration
REQ-035 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the port not granted most recently wins; the last-grant pointer updates only on contention-free or contested grants, never on idle cycles.
REQ-036 Macro undefined: fixed priority per REQ-030; no pointer register is synthesised.

Structure
REQ-037 Shared package philv_mem_pkg holds N default, the port-ID typedef (PORT_IF, PORT_LS), and the owner/response record type.
REQ-038 Sub-module mem_arb_pick: pure two-way grant selection (fixed or round-robin), instantiated once.

Verification
REQ-039 if_req, addr 0x10, MEM[4]=0xDEADBEEF -> if_gnt same cycle, if_rvalid next cycle, if_rdata=0xDEADBEEF.
REQ-040 ls store 0x20/0x12345678, then ls load 0x20 next cycle -> ack with ls_rdata=0, then ls_rdata=0x12345678.
REQ-041 if_req and ls_req held 4 cycles, fixed priority -> ls granted 4 times, if 0; with MEM_ARB_ROUND_ROBIN_EN -> grants alternate ls,if,ls,if.
REQ-042 ls load addr 0x22 -> ls_gnt, mem_rdEna=0, next cycle ls_rvalid=1, ls_err=1, ls_rdata=0.
REQ-043 rst asserted the cycle after a fetch grant -> no if_rvalid at any later cycle; all outputs 0 during reset.
REQ-044 Back-to-back fetches 0x0,0x4,0x8 every cycle -> three consecutive if_rvalid cycles with data MEM[0],MEM[1],MEM[2].
